id_decode_queue: RTL
====================

Name: id_decode_queue

Overview:
- Parametrised instruction queue that sits between IF and the ID decoder.
- Buffers {pc, inst, exception_type} tuples from fetch using a valid/ready handshake.
- Pre-decodes control-transfer instructions at push time. It tags delay slots, resolves J/JAL targets and, optionally, holds a branch until its delay slot is queued.
- Replaces the single-register delay_slot tracking in decode. This lets fetch run ahead of decode stalls.

Parameters:
DEPTH, 4, number of entries; power of two, minimum 2
ADDR_W, 32, pc width
DATA_W, 32, instruction width
EXC_W, 32, exception_type vector width
BR_PAIR, 1, 1 = branch/jump not presented until its delay-slot instruction is also queued

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  reset, asynchronous, active-high
flush  in  1  synchronous flush from CP0/exception logic
in_valid  in  1  fetch offers an entry
in_ready  out  1  queue accepts; equals (count < DEPTH)
in_pc  in  ADDR_W  fetched pc
in_inst  in  DATA_W  fetched instruction
in_exc  in  EXC_W  fetch-side exception_type
out_valid  out  1  head entry presented to ID
out_ready  in  1  ID consumes head (ID not stalled)
out_pc  out  ADDR_W  head pc
out_inst  out  DATA_W  head instruction
out_exc  out  EXC_W  head exception_type, unmodified
out_is_branch  out  1  head is a control transfer
out_delay_slot  out  1  head is the delay slot of the previously pushed branch
out_br_flag  out  1  head is J/JAL
out_br_addr  out  ADDR_W  {pc[31:28], inst[25:0], 2'b00} for J/JAL, else 0
count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset (rst=1, async): head/tail pointers=0, count=0, last_push_branch=0.
  - All out_* = 0; in_ready = 1 once rst deasserts.
- push = in_valid & in_ready. pop = out_valid & out_ready.
- Both push and pop are registered on posedge. Simultaneous push and pop leaves count unchanged.
- Latency: an entry pushed at edge N is visible at the head at edge N+1 at the earliest. There is no bypass.
- in_ready does not depend on out_ready. At full, a push is refused even if a pop occurs in the same cycle.
- Pointers wrap modulo DEPTH. Storage is an array of DEPTH entries, each {pc, inst, exc, is_branch, delay_slot}.
- is_branch is computed at push:
  - SPECIAL (000000) with funct JR 001000 or JALR 001001.
  - Opcodes BEQ 000100, BNE 000101, BLEZ 000110, BGTZ 000111, J 000010, JAL 000011.
  - REGIMM (000001) with rt BLTZ 00000, BGEZ 00001, BLTZAL 10000, BGEZAL 10001.
- delay_slot stored on push = last_push_branch. On every push, last_push_branch takes the pushed is_branch.
- A branch in a delay slot has both flags set.
- out_br_flag and out_br_addr are derived combinationally from the head entry. They are forced to 0 when out_valid=0.
- out_valid = (count != 0) & ~hold.
  - hold = BR_PAIR & head.is_branch & (count == 1).
  - While hold=1, out_* data fields are driven to 0.
- flush=1 at a posedge:
  - count=0, pointers=0, last_push_branch=0.
  - Any push or pop in that cycle is discarded.
  - in_ready stays 1 (count=0 after flush).
- rst asserted mid-operation: immediate return to reset values regardless of clk.
- Occupancy never exceeds DEPTH and never underflows.
- Pops with count=0 are impossible because out_valid=0.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with 3 entries queued -> count=0, out_valid=0, out_pc=0 immediately. After release, in_ready=1.
- Fill/wrap (DEPTH=4), out_ready=0:
  - Push pc 0x100..0x10C -> in_ready=0 at count=4.
  - Pop 2 and push 0x110, 0x114 -> pops return 0x100, 0x104, then 0x108..0x114 in order after wrap.
- J decode: push pc=0xBFC00010 inst=0x08000040 then a nop -> head out_br_flag=1, out_br_addr=0xB0000100. The nop has out_delay_slot=1.
- Pair hold: BR_PAIR=1, push BEQ 0x10220003 alone -> out_valid=0 for all cycles.
  - Push the next inst -> out_valid=1 on the following cycle; the second entry has out_delay_slot=1.
- Flush: 3 entries queued, flush=1 together with in_valid=1 -> count=0 next cycle, and the pushed entry is lost.
  - The next push after a branch was queued pre-flush -> out_delay_slot=0.
- Simultaneous push/pop at count=2 -> count stays 2; FIFO order preserved; REGIMM BGEZAL (rt=10001) -> out_is_branch=1.

Source files
------------

// File: rtl/id_decode_queue.sv
// Instruction queue between IF and ID: buffers fetched {pc, inst, exc} tuples,
// pre-decodes control transfers at push time and tracks delay slots.
module id_decode_queue #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int EXC_W   = 32,
    parameter int BR_PAIR = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_pc,
    input  logic [DATA_W-1:0]        in_inst,
    input  logic [EXC_W-1:0]         in_exc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDR_W-1:0]        out_pc,
    output logic [DATA_W-1:0]        out_inst,
    output logic [EXC_W-1:0]         out_exc,
    output logic                     out_is_branch,
    output logic                     out_delay_slot,
    output logic                     out_br_flag,
    output logic [ADDR_W-1:0]        out_br_addr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;

    function automatic logic is_ctrl(input logic [DATA_W-1:0] inst);
        logic [5:0] op;
        logic [5:0] funct;
        logic [4:0] rt;
        op    = inst[31:26];
        funct = inst[5:0];
        rt    = inst[20:16];
        case (op)
            OP_SPECIAL: is_ctrl = (funct == 6'b001000) || (funct == 6'b001001);
            OP_REGIMM:  is_ctrl = (rt == 5'b00000) || (rt == 5'b00001) ||
                                  (rt == 5'b10000) || (rt == 5'b10001);
            OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: is_ctrl = 1'b1;
            default:    is_ctrl = 1'b0;
        endcase
    endfunction

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [DATA_W-1:0] inst_mem [DEPTH];
    logic [EXC_W-1:0]  exc_mem  [DEPTH];
    logic [DEPTH-1:0]  br_mem;
    logic [DEPTH-1:0]  ds_mem;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             last_push_branch;

    logic push;
    logic pop;
    logic in_is_branch;
    logic hold;
    logic head_br;
    logic head_j;
    logic [ADDR_W-1:0] head_pc;
    logic [DATA_W-1:0] head_inst;

    assign in_ready     = (count < CNT_W'(DEPTH));
    assign push         = in_valid & in_ready;
    assign pop          = out_valid & out_ready;
    assign in_is_branch = is_ctrl(in_inst);

    // Storage carries no reset; occupancy gating keeps stale contents invisible.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            pc_mem[tail]   <= in_pc;
            inst_mem[tail] <= in_inst;
            exc_mem[tail]  <= in_exc;
            br_mem[tail]   <= in_is_branch;
            ds_mem[tail]   <= last_push_branch;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            last_push_branch <= 1'b0;
        end else if (flush) begin
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            last_push_branch <= 1'b0;
        end else begin
            if (push) begin
                tail             <= tail + PTR_W'(1);
                last_push_branch <= in_is_branch;
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_pc   = pc_mem[head];
    assign head_inst = inst_mem[head];
    assign head_br   = br_mem[head];
    assign head_j    = (head_inst[31:26] == OP_J) || (head_inst[31:26] == OP_JAL);

    // A lone branch waits until its delay-slot instruction has been queued behind it.
    assign hold      = (BR_PAIR != 0) && head_br && (count == CNT_W'(1));
    assign out_valid = (count != '0) && !hold;

    always_comb begin
        out_pc         = '0;
        out_inst       = '0;
        out_exc        = '0;
        out_is_branch  = 1'b0;
        out_delay_slot = 1'b0;
        out_br_flag    = 1'b0;
        out_br_addr    = '0;
        if (out_valid) begin
            out_pc         = head_pc;
            out_inst       = head_inst;
            out_exc        = exc_mem[head];
            out_is_branch  = head_br;
            out_delay_slot = ds_mem[head];
            out_br_flag    = head_j;
            if (head_j) begin
                out_br_addr = {head_pc[ADDR_W-1:28], head_inst[25:0], 2'b00};
            end
        end
    end

endmodule
